ste_dice_game_ctrl: RTL

- Two-player turn scheduler for a bank of NUM_DICE dice modules.
- On a roll request it fires one trigger pulse to every die, then collects each die's done pulse and result.
- It sums the result into the current player's score, applies the doubles/extra-turn rule, and declares a winner at TARGET_SCORE.
- Sits between the debounced btnC edge pulse and the dice instances; drives the scoreboard display.

---
 rtl/ste_dice_pkg.sv | 24 ++
 rtl/ste_dice_result_collect.sv | 57 +++++
 rtl/ste_dice_game_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ste_dice_pkg.sv
// Shared types and constants for the two-player dice game controller.
package ste_dice_pkg;

  localparam int DICE_W  = 3;
  localparam int SCORE_W = 8;

  localparam logic [DICE_W-1:0] DICE_MIN = 3'd1;
  localparam logic [DICE_W-1:0] DICE_MAX = 3'd6;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_FIRE  = 3'd1,
    GS_WAIT  = 3'd2,
    GS_ACCUM = 3'd3,
    GS_CHECK = 3'd4,
    GS_OVER  = 3'd5
  } ste_game_state_e;

  // A face value outside 1..6 counts as zero.
  function automatic logic [DICE_W-1:0] dice_clip(input logic [DICE_W-1:0] v);
    return ((v >= DICE_MIN) && (v <= DICE_MAX)) ? v : '0;
  endfunction

endpackage

// File: rtl/ste_dice_result_collect.sv
// Collects per-die done pulses and results for one roll; provides the
// completion flag, the sum of captured faces and the doubles flag.
module ste_dice_result_collect
  import ste_dice_pkg::*;
#(
  parameter int NUM_DICE = 2
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         arm_i,
  input  logic                         sample_i,
  input  logic [NUM_DICE-1:0]          dice_done_i,
  input  logic [DICE_W*NUM_DICE-1:0]   dice_dout_i,
  output logic                         all_done_o,
  output logic [SCORE_W-1:0]           sum_o,
  output logic                         doubles_o
);

  logic [NUM_DICE-1:0] r_mask;
  logic [DICE_W-1:0]   r_cap [NUM_DICE];
  logic [NUM_DICE-1:0] w_done_in;
  logic [SCORE_W-1:0]  w_sum;
  logic                w_same;

  assign w_done_in = sample_i ? dice_done_i : '0;

  // Includes pulses arriving this cycle, so the last done moves the FSM on
  // at the next edge and a done on the final timeout cycle still counts.
  assign all_done_o = &(r_mask | w_done_in);

  always_ff @(posedge clk) begin
    if (reset_i || clear_i) begin
      r_mask <= '0;
      for (int k = 0; k < NUM_DICE; k++) r_cap[k] <= '0;
    end else begin
      if (arm_i) r_mask <= '0;
      else       r_mask <= r_mask | w_done_in;
      for (int k = 0; k < NUM_DICE; k++) begin
        if (w_done_in[k]) r_cap[k] <= dice_clip(dice_dout_i[k*DICE_W +: DICE_W]);
      end
    end
  end

  always_comb begin
    w_sum  = '0;
    w_same = 1'b1;
    for (int k = 0; k < NUM_DICE; k++) begin
      w_sum = w_sum + SCORE_W'(r_cap[k]);
      if (r_cap[k] != r_cap[0]) w_same = 1'b0;
    end
  end

  assign sum_o     = w_sum;
  assign doubles_o = (NUM_DICE >= 2) && w_same;

endmodule

// File: rtl/ste_dice_game_ctrl.sv
// Two-player turn scheduler: triggers the dice bank, collects results,
// keeps saturating scores, applies the doubles rule and declares a winner.
module ste_dice_game_ctrl
  import ste_dice_pkg::*;
#(
  parameter int         NUM_DICE       = 2,
  parameter logic [7:0] TARGET_SCORE   = 8'd50,
  parameter logic [9:0] TIMEOUT_CYCLES = 10'd1023
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       roll_req_i,
  input  logic                       new_game_i,
  output logic [NUM_DICE-1:0]        dice_trig_o,
  input  logic [NUM_DICE-1:0]        dice_done_i,
  input  logic [DICE_W*NUM_DICE-1:0] dice_dout_i,
  output logic                       busy_o,
  output logic                       cur_player_o,
  output logic [SCORE_W-1:0]         score0_o,
  output logic [SCORE_W-1:0]         score1_o,
  output logic [SCORE_W-1:0]         last_sum_o,
  output logic                       winner_valid_o,
  output logic                       winner_o,
  output logic                       timeout_o,
  output logic [2:0]                 dbg_state_o
);

  localparam logic [2:0] ST_IDLE  = 3'(GS_IDLE);
  localparam logic [2:0] ST_FIRE  = 3'(GS_FIRE);
  localparam logic [2:0] ST_WAIT  = 3'(GS_WAIT);
  localparam logic [2:0] ST_ACCUM = 3'(GS_ACCUM);
  localparam logic [2:0] ST_CHECK = 3'(GS_CHECK);
  localparam logic [2:0] ST_OVER  = 3'(GS_OVER);

  logic [2:0]         r_state;
  logic [9:0]         r_cnt;
  logic               r_player;
  logic [SCORE_W-1:0] r_score0;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_last_sum;
  logic               r_win_valid;
  logic               r_winner;
  logic               r_timeout;

  logic               w_fire;
  logic               w_wait;
  logic               w_all_done;
  logic               w_doubles;
  logic [SCORE_W-1:0] w_sum;
  logic [SCORE_W-1:0] w_cur_score;
  logic [SCORE_W:0]   w_wide;
  logic [SCORE_W-1:0] w_new_score;

  assign w_fire = (r_state == ST_FIRE);
  assign w_wait = (r_state == ST_WAIT);

  // Dice protocol: each die gets a one-cycle trigger and answers later with
  // a one-cycle done pulse, its face on dice_dout_i valid in that same cycle.
  // There is no back-pressure; pulses outside WAIT are simply not sampled.
  ste_dice_result_collect #(
    .NUM_DICE (NUM_DICE)
  ) u_collect (
    .clk         (clk),
    .reset_i     (reset_i),
    .clear_i     (new_game_i),
    .arm_i       (w_fire),
    .sample_i    (w_wait),
    .dice_done_i (dice_done_i),
    .dice_dout_i (dice_dout_i),
    .all_done_o  (w_all_done),
    .sum_o       (w_sum),
    .doubles_o   (w_doubles)
  );

  assign w_cur_score = r_player ? r_score1 : r_score0;
  assign w_wide      = {1'b0, w_cur_score} + {1'b0, w_sum};
  assign w_new_score = w_wide[SCORE_W] ? {SCORE_W{1'b1}} : w_wide[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset_i || new_game_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_player    <= 1'b0;
      r_score0    <= '0;
      r_score1    <= '0;
      r_last_sum  <= '0;
      r_win_valid <= 1'b0;
      r_winner    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (roll_req_i) r_state <= ST_FIRE;
        end
        ST_FIRE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 10'd1;
          if (w_all_done) begin
            r_state <= ST_ACCUM;
          end else if (r_cnt == TIMEOUT_CYCLES - 10'd1) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end
        end
        ST_ACCUM: begin
          r_last_sum <= w_sum;
          if (r_player) r_score1 <= w_new_score;
          else          r_score0 <= w_new_score;
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_cur_score >= TARGET_SCORE) begin
            r_winner    <= r_player;
            r_win_valid <= 1'b1;
            r_state     <= ST_OVER;
          end else begin
            if (!w_doubles) r_player <= ~r_player;
            r_state <= ST_IDLE;
          end
        end
        ST_OVER: begin
          r_state <= ST_OVER;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dice_trig_o    = {NUM_DICE{w_fire}};
  assign busy_o         = (r_state != ST_IDLE) && (r_state != ST_OVER);
  assign cur_player_o   = r_player;
  assign score0_o       = r_score0;
  assign score1_o       = r_score1;
  assign last_sum_o     = r_last_sum;
  assign winner_valid_o = r_win_valid;
  assign winner_o       = r_winner;
  assign timeout_o      = r_timeout;
  assign dbg_state_o    = r_state;

endmodule
